gate_channel_scheduler: RTL and testbench
=========================================

# gate_channel_scheduler

Time-multiplexes one shared noise-gate core across NUM_CH audio channels. Arbitrates per-channel sample requests round-robin and issues one sample per cycle to the core. Saves and restores each channel's envelope state around the core's fixed-latency pipeline. Collects results in an ordered output FIFO with credit-based back-pressure. Sits between the per-channel sample front end and the downstream mixer/amplifier stage.

## Interface
- NUM_CH, 4, number of channels (2..8)
- DATA_W, 24, sample and envelope width (two's complement sample, unsigned envelope)
- OUT_DEPTH, 4, output FIFO entries; also the total credit limit
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  run request; low stops new grants and drains in-flight work
- clear_env  in  1  one-cycle pulse; zeroes the envelope bank
- in_valid  in  NUM_CH  per-channel sample available
- in_data  in  NUM_CH*DATA_W  per-channel samples; channel i occupies bits [i*DATA_W +: DATA_W]
- in_ready  out  NUM_CH  one-hot grant; the sample is consumed in that cycle
- core_valid  out  1  issue strobe to the core
- core_ch  out  $clog2(NUM_CH)  channel tag of the issued sample
- core_data  out  DATA_W  issued sample
- core_env  out  DATA_W  restored envelope for core_ch
- core_rvalid  in  1  core result strobe
- core_rch  in  $clog2(NUM_CH)  result channel tag
- core_rdata  in  DATA_W  gated sample
- core_renv  in  DATA_W  updated envelope
- out_valid  out  1  FIFO non-empty
- out_ch  out  $clog2(NUM_CH)  head channel
- out_data  out  DATA_W  head sample
- out_ready  in  1  downstream accept
- busy  out  1  high in RUN or DRAIN, or when the FIFO is non-empty
- proto_err  out  1  sticky flag: core returned a result for a channel with no sample in flight

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE→RUN when enable=1.
  - RUN→DRAIN when enable=0 and inflight_cnt>0.
  - RUN→IDLE when enable=0 and inflight_cnt=0.
  - DRAIN→IDLE when inflight_cnt reaches 0.
  - DRAIN→RUN when enable=1.
- **Grant eligibility:** channel i is eligible only if all of the following hold:
  - state=RUN;
  - in_valid[i]=1;
  - inflight[i]=0;
  - fifo_cnt + inflight_cnt < OUT_DEPTH.
- **Arbitration:**
  - At most one grant per cycle.
  - Search starts at last_grant+1 and wraps modulo NUM_CH.
  - last_grant resets to NUM_CH-1, so channel 0 has first priority.
- **Grant cycle:**
  - in_ready[i]=1 (combinational).
  - core_valid, core_ch, core_data and core_env are driven combinationally in the same cycle; core_env = env_bank[i].
  - inflight[i] sets on the clock edge.
- **Result cycle (core_rvalid=1):**
  - env_bank[core_rch] ← core_renv.
  - inflight[core_rch] clears.
  - {core_rch, core_rdata} is pushed to the FIFO.
  - If inflight[core_rch] was already 0: set proto_err; drop the FIFO push and the envelope write.
- **Re-grant timing:** a channel is re-grantable no earlier than the cycle after its result writes back. This prevents stale-envelope hazards.
- **clear_env:**
  - Zeroes all env_bank entries.
  - If a result arrives in the same cycle, clear wins for every entry.
  - In-flight tracking is unaffected.
- **FIFO:**
  - Pop when out_valid and out_ready are both high.
  - A simultaneous push and pop leaves fifo_cnt unchanged.
  - Overflow cannot occur by construction, because the credit check reserves a slot for every issued sample.
- **Arithmetic:**
  - inflight_cnt = popcount(inflight), width $clog2(NUM_CH+1).
  - fifo_cnt width $clog2(OUT_DEPTH+1).
  - The credit sum is compared without truncation.

## Timing
- **Reset values:**
  - Outputs: in_ready=0, core_valid=0, out_valid=0, busy=0, proto_err=0.
  - Internal: env_bank all 0, inflight=0, FIFO empty, state=IDLE.
- **Reset asserted mid-operation:**
  - All of the above return to reset values immediately.
  - Results arriving after reset are flagged as proto_err.
- **Latency:**
  - Grant to core_valid: 0 cycles.
  - core_rvalid to out_valid: 1 cycle (registered FIFO write).
- **Throughput:**
  - 1 sample/cycle when at least 2 channels are active.
  - A single active channel is limited to one sample per (core latency + 1) cycles.

## Test plan
- **Reset and idle:** reset, enable=0, in_valid=4'b1111 → in_ready=0 and core_valid=0 for 20 cycles; busy=0.
- **Round-robin:** enable=1, all channels valid, core latency 2, out_ready=1 → grant order 0,1,2,3,0…; output channel order matches; no channel is granted twice within 3 cycles.
- **Envelope save/restore:** ch1 result core_renv=24'h001234 → next ch1 issue drives core_env=24'h001234; ch2 still drives 0.
- **Back-pressure:** out_ready=0, latency 2 → exactly 4 grants, then in_ready stays 0. Raising out_ready for 1 cycle → exactly one new grant after the pop.
- **Drain:** drop enable with 2 samples in flight → no new grants; both results reach the FIFO; state reaches IDLE; busy falls after the FIFO empties.
- **Error and clear:**
  - Inject core_rvalid for ch3 with inflight[3]=0 → proto_err=1 and stays set; FIFO count unchanged.
  - clear_env in the same cycle as a ch0 result → env_bank[0]=0.

Source files
------------

// File: rtl/gate_channel_scheduler.sv
// gate_channel_scheduler: round-robin issue of per-channel samples to a shared gate core, with envelope save/restore and a credit-limited ordered output FIFO
module gate_channel_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 24,
  parameter int OUT_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clear_env,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH*DATA_W-1:0]    in_data,
  output logic [NUM_CH-1:0]           in_ready,
  output logic                        core_valid,
  output logic [$clog2(NUM_CH)-1:0]   core_ch,
  output logic [DATA_W-1:0]           core_data,
  output logic [DATA_W-1:0]           core_env,
  input  logic                        core_rvalid,
  input  logic [$clog2(NUM_CH)-1:0]   core_rch,
  input  logic [DATA_W-1:0]           core_rdata,
  input  logic [DATA_W-1:0]           core_renv,
  output logic                        out_valid,
  output logic [$clog2(NUM_CH)-1:0]   out_ch,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        proto_err
);
  localparam int CW = $clog2(NUM_CH);
  localparam int IW = $clog2(NUM_CH + 1);
  localparam int FW = $clog2(OUT_DEPTH + 1);
  localparam int PW = $clog2(OUT_DEPTH);
  localparam int SW = (IW > FW ? IW : FW) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] env_bank [NUM_CH];
  logic [CW+DATA_W-1:0] fifo_mem [OUT_DEPTH];
  logic [NUM_CH-1:0] inflight, elig, res_mask;
  logic [IW-1:0] inflight_cnt;
  logic [FW-1:0] fifo_cnt;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] last_grant, gnt_ch;
  logic [SW-1:0] credit_sum;
  logic gnt, res_ok, push, pop;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) inflight_cnt = inflight_cnt + IW'(inflight[i]);
  end

  // every in-flight sample already owns a FIFO slot, so this check alone rules out overflow
  assign credit_sum = SW'(fifo_cnt) + SW'(inflight_cnt);
  assign elig = (state == RUN && credit_sum < SW'(OUT_DEPTH)) ? in_valid & ~inflight : '0;

  always_comb begin
    gnt = 1'b0;
    gnt_ch = '0;
    for (int k = 1; k <= NUM_CH; k++)
      if (!gnt && elig[(int'(last_grant) + k) % NUM_CH]) begin
        gnt = 1'b1;
        gnt_ch = CW'((int'(last_grant) + k) % NUM_CH);
      end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = enable ? RUN : IDLE;
      RUN:     state_nx = enable ? RUN : (inflight_cnt != '0 ? DRAIN : IDLE);
      DRAIN:   state_nx = enable ? RUN : (inflight_cnt == '0 ? IDLE : DRAIN);
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready   = gnt ? NUM_CH'(1) << gnt_ch : '0;
  assign core_valid = gnt;
  assign core_ch    = gnt_ch;
  assign core_data  = in_data[int'(gnt_ch)*DATA_W +: DATA_W];
  assign core_env   = env_bank[gnt_ch];
  assign res_ok     = core_rvalid && inflight[core_rch];
  assign res_mask   = core_rvalid ? NUM_CH'(1) << core_rch : '0;
  assign push       = res_ok;
  assign pop        = out_valid && out_ready;
  assign out_valid  = fifo_cnt != '0;
  assign {out_ch, out_data} = fifo_mem[rd_ptr];
  assign busy       = state != IDLE || out_valid;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      inflight   <= '0;
      last_grant <= CW'(NUM_CH - 1);
      proto_err  <= 1'b0;
      fifo_cnt   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      for (int i = 0; i < NUM_CH; i++) env_bank[i] <= '0;
    end else begin
      state    <= state_nx;
      inflight <= (inflight & ~res_mask) | in_ready;
      if (gnt) last_grant <= gnt_ch;
      if (core_rvalid && !inflight[core_rch]) proto_err <= 1'b1;
      for (int i = 0; i < NUM_CH; i++)
        if (clear_env) env_bank[i] <= '0;
        else if (res_ok && CW'(i) == core_rch) env_bank[i] <= core_renv;
      if (push) wr_ptr <= wr_ptr == PW'(OUT_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(OUT_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + FW'(push) - FW'(pop);
    end

  always_ff @(posedge clk)
    if (push) fifo_mem[wr_ptr] <= {core_rch, core_rdata};
endmodule

// File: tb/tb_gate_channel_scheduler.sv
// tb_gate_channel_scheduler: directed bench with a 2-cycle gate-core model and an output scoreboard
module tb_gate_channel_scheduler;
  localparam int N = 4, W = 24, D = 4;
  localparam logic [W-1:0] GATE_MASK = 24'hA5A5A5, ENV_STEP = 24'h001234;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clear_env = 1'b0, out_ready = 1'b0;
  logic [N-1:0] in_valid = '0, in_ready;
  logic [N*W-1:0] in_data;
  logic core_valid, out_valid, busy, proto_err;
  logic [1:0] core_ch, out_ch;
  logic core_rvalid = 1'b0;
  logic [1:0] core_rch = '0;
  logic [W-1:0] core_rdata = '0, core_renv = '0;
  logic [W-1:0] core_data, core_env, out_data;
  logic [W-1:0] samp [N];
  logic [W-1:0] tb_env [N];
  logic [W+1:0] sb [$];
  int tests = 0, fails = 0, cyc = 0, gcount = 0, seq = 0;
  int last_cyc [N];
  int last_ch = 0, last_gcyc = 0, rr_exp = 0, g0 = 0, t1 = 0;
  logic granted = 1'b0, rr_chk = 1'b0;
  logic [W-1:0] last_env = '0;
  logic s0_v = 1'b0, s1_v = 1'b0;
  logic [1:0] s0_ch = '0, s1_ch = '0;
  logic [W-1:0] s0_d = '0, s1_d = '0, s0_e = '0, s1_e = '0;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) in_data[i*W +: W] = samp[i];

  gate_channel_scheduler #(.NUM_CH(N), .DATA_W(W), .OUT_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear_env(clear_env),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .core_valid(core_valid), .core_ch(core_ch), .core_data(core_data), .core_env(core_env),
    .core_rvalid(core_rvalid), .core_rch(core_rch), .core_rdata(core_rdata), .core_renv(core_renv),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: check issue and output at mid-low-phase, then advance the core model
  task automatic tick();
    int g = 0;
    logic [W-1:0] ie = '0;
    logic [W+1:0] e;
    #1;
    granted = core_valid;
    if (rr_chk) chk("rr_throughput", 32'(core_valid), 1);
    if (core_valid) begin
      g = int'(core_ch);
      ie = tb_env[g];
      chk("in_ready_onehot", 32'(in_ready), 32'(1) << g);
      chk("core_data", 32'(core_data), 32'(samp[g]));
      chk("core_env", 32'(core_env), 32'(ie));
      if (rr_chk) begin
        chk("rr_order", g, rr_exp);
        chk("rr_spacing", 32'(cyc - last_cyc[g] >= 3), 1);
        rr_exp = (rr_exp + 1) % N;
      end
      last_cyc[g] = cyc;
      last_ch = g;
      last_gcyc = cyc;
      last_env = core_env;
      gcount++;
      sb.push_back({2'(g), samp[g] ^ GATE_MASK});
    end else
      chk("in_ready_idle", 32'(in_ready), 0);
    if (out_valid && out_ready) begin
      if (sb.size() > 0) e = sb.pop_front();
      else e = 'x;
      chk("out_ch", 32'(out_ch), 32'(e[W+1:W]));
      chk("out_data", 32'(out_data), 32'(e[W-1:0]));
    end
    @(posedge clk);
    cyc++;
    if (clear_env) for (int i = 0; i < N; i++) tb_env[i] = '0;
    else if (core_rvalid && s1_v) tb_env[s1_ch] = s1_e;
    #1;
    {s1_v, s1_ch, s1_d, s1_e} = {s0_v, s0_ch, s0_d, s0_e};
    s0_v = granted;
    s0_ch = 2'(g);
    s0_d = samp[g] ^ GATE_MASK;
    s0_e = ie + ENV_STEP;
    {core_rvalid, core_rch, core_rdata, core_renv} = {s1_v, s1_ch, s1_d, s1_e};
    if (granted) begin
      seq++;
      samp[g] = 24'(seq * 40503 + g * 7);
    end
    clear_env = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_grant(input int ch);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(granted && last_ch == ch) && n < 20);
    chk("wait_grant", 32'(granted && last_ch == ch), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      samp[i] = 24'h010000 * 24'(i + 1) + 24'h000101;
      tb_env[i] = '0;
      last_cyc[i] = -100;
    end
    in_valid = 4'hF;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_core_valid", 32'(core_valid), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (20) begin
      tick();
      chk("idle_no_grant", 32'(core_valid), 0);
    end
    chk("idle_busy", 32'(busy), 0);
    out_ready = 1'b1;
    enable = 1'b1;
    tick();
    rr_chk = 1'b1;
    rr_exp = 0;
    repeat (12) tick();
    rr_chk = 1'b0;
    enable = 1'b0;
    in_valid = '0;
    wait_idle(30);
    chk("rr_sb_empty", 32'(sb.size()), 0);
    clear_env = 1'b1;
    tick();
    in_valid = 4'b0010;
    enable = 1'b1;
    wait_grant(1);
    chk("env_first", 32'(last_env), 0);
    t1 = last_gcyc;
    wait_grant(1);
    chk("env_restore", 32'(last_env), 32'h001234);
    chk("single_ch_rate", last_gcyc - t1, 3);
    in_valid = 4'b0100;
    wait_grant(2);
    chk("env_other_ch", 32'(last_env), 0);
    in_valid = '0;
    enable = 1'b0;
    wait_idle(30);
    out_ready = 1'b0;
    in_valid = 4'hF;
    enable = 1'b1;
    g0 = gcount;
    repeat (12) tick();
    chk("bp_grants", gcount - g0, 4);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    g0 = gcount;
    repeat (6) tick();
    chk("bp_one_grant", gcount - g0, 1);
    enable = 1'b0;
    in_valid = '0;
    out_ready = 1'b1;
    wait_idle(30);
    chk("bp_sb_empty", 32'(sb.size()), 0);
    out_ready = 1'b0;
    in_valid = 4'hF;
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    tick();
    chk("drain_busy", 32'(busy), 1);
    g0 = gcount;
    repeat (8) tick();
    chk("drain_no_grant", gcount - g0, 0);
    chk("drain_fifo_holds_busy", 32'(busy), 1);
    chk("drain_out_valid", 32'(out_valid), 1);
    in_valid = '0;
    out_ready = 1'b1;
    wait_idle(20);
    chk("drain_sb_empty", 32'(sb.size()), 0);
    clear_env = 1'b1;
    tick();
    chk("err_clean", 32'(proto_err), 0);
    {core_rvalid, core_rch, core_rdata, core_renv} = {1'b1, 2'd3, 24'h777777, 24'h00BEEF};
    tick();
    chk("err_set", 32'(proto_err), 1);
    chk("err_no_push", 32'(out_valid), 0);
    repeat (3) tick();
    chk("err_sticky", 32'(proto_err), 1);
    in_valid = 4'b1000;
    enable = 1'b1;
    wait_grant(3);
    chk("err_env_untouched", 32'(last_env), 0);
    in_valid = 4'b0001;
    wait_grant(0);
    tick();
    clear_env = 1'b1;
    tick();
    wait_grant(0);
    chk("clear_wins", 32'(last_env), 0);
    in_valid = '0;
    enable = 1'b0;
    wait_idle(20);
    chk("final_sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
